pll_cfg_writer: RTL and testbench

// Configuration master for the digital PLL: drives its enable, dco, div[4:0] and ext_trim[25:0] inputs.

---
 rtl/pll_cfg_writer_pkg.sv | 30 +++
 rtl/pll_cfg_writer_if.sv | 35 +++
 rtl/pll_cfg_writer_timer.sv | 36 +++
 rtl/pll_cfg_writer.sv | 133 +++++++++++++
 tb/tb_pll_cfg_writer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pll_cfg_writer_pkg.sv
// -----------------------------------------------------------------------------
// pll_cfg_pkg
// Shared definitions for the PLL configuration writer: bus widths, the divider
// value driven out of reset, the sequencer state encoding and the captured
// configuration record.
// -----------------------------------------------------------------------------
package pll_cfg_pkg;

  localparam int DIV_W  = 5;
  localparam int TRIM_W = 26;

  localparam logic [DIV_W-1:0] RESET_DIV = 5'd4;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    LOAD,
    SETTLE,
    LOCK
  } state_t;

  // One host request as captured on the handshake.
  typedef struct packed {
    logic              enable;
    logic              dco;
    logic [DIV_W-1:0]  div;
    logic [TRIM_W-1:0] trim;
  } cfg_t;

endpackage

// File: rtl/pll_cfg_writer_if.sv
// -----------------------------------------------------------------------------
// pll_cfg_writer_if
// Host-side request channel of the PLL configuration writer.
//   req_valid/req_ready   valid/ready handshake, one config word per transfer
//   req_div/req_trim      requested divider / external trim
//   req_dco               requested dco mode (1 = external trim)
//   req_enable            re-enable the oscillator after loading
//   busy                  sequence in progress
//   done                  one-cycle pulse when a sequence completes
// master = host, slave = writer.
// -----------------------------------------------------------------------------
import pll_cfg_pkg::*;

interface pll_cfg_writer_if;

  logic              req_valid;
  logic              req_ready;
  logic [DIV_W-1:0]  req_div;
  logic [TRIM_W-1:0] req_trim;
  logic              req_dco;
  logic              req_enable;
  logic              busy;
  logic              done;

  modport master (
    output req_valid, req_div, req_trim, req_dco, req_enable,
    input  req_ready, busy, done
  );

  modport slave (
    input  req_valid, req_div, req_trim, req_dco, req_enable,
    output req_ready, busy, done
  );

endinterface

// File: rtl/pll_cfg_writer_timer.sv
// -----------------------------------------------------------------------------
// pll_cfg_timer
// Loadable down-counter used to time the quiesce, load and lock intervals.
//   clock   rising-edge clock
//   resetb  asynchronous active-low reset (count clears to 0)
//   load    load strobe; takes priority over counting
//   value   value loaded when load is high
//   zero    high while the count is 0
// The count saturates at 0 rather than wrapping.
// -----------------------------------------------------------------------------
module pll_cfg_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pll_cfg_writer.sv
// -----------------------------------------------------------------------------
// pll_cfg_writer
// Configuration master for the digital PLL. Accepts one configuration word per
// handshake and applies it glitch-safely: hold the oscillator disabled, load
// the new divider/trim/dco, let them settle, optionally re-enable and wait for
// lock, then pulse done.
//   clock         reference oscillator clock (always-on domain)
//   resetb        asynchronous active-low reset
//   host          request channel (slave side)
//   pll_enable    PLL enable
//   pll_dco       PLL dco mode select
//   pll_div       PLL divider
//   pll_ext_trim  PLL external trim
// pll_div/pll_ext_trim/pll_dco only change while pll_enable is low.
// -----------------------------------------------------------------------------
import pll_cfg_pkg::*;

module pll_cfg_writer #(
  parameter int QUIESCE_CYC = 8,
  parameter int LOAD_CYC    = 4,
  parameter int LOCK_CYC    = 64,
  parameter int CNT_W       = 16
) (
  input  logic               clock,
  input  logic               resetb,
  pll_cfg_writer_if.slave    host,
  output logic               pll_enable,
  output logic               pll_dco,
  output logic [DIV_W-1:0]   pll_div,
  output logic [TRIM_W-1:0]  pll_ext_trim
);

  state_t           state;
  cfg_t             cap;
  logic             done_q;
  logic             xfer;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_zero;

  // Ready is a pure decode of the state register, never of req_valid.
  assign host.req_ready = (state == IDLE);
  assign host.busy      = (state != IDLE);
  assign host.done      = done_q;
  assign xfer           = host.req_valid && (state == IDLE);

  // Timer reload points: entering QUIESCE, SETTLE and LOCK.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      IDLE: begin
        if (xfer) begin
          timer_load  = 1'b1;
          timer_value = CNT_W'(QUIESCE_CYC - 1);
        end
      end
      LOAD: begin
        timer_load  = 1'b1;
        timer_value = CNT_W'(LOAD_CYC - 1);
      end
      SETTLE: begin
        if (timer_zero && cap.enable) begin
          timer_load  = 1'b1;
          timer_value = CNT_W'(LOCK_CYC - 1);
        end
      end
      default: ;
    endcase
  end

  pll_cfg_timer #(.CNT_W(CNT_W)) u_timer (
    .clock  (clock),
    .resetb (resetb),
    .load   (timer_load),
    .value  (timer_value),
    .zero   (timer_zero)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state        <= IDLE;
      cap          <= '0;
      done_q       <= 1'b0;
      pll_enable   <= 1'b0;
      pll_dco      <= 1'b0;
      pll_div      <= RESET_DIV;
      pll_ext_trim <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            cap <= '{enable: host.req_enable, dco: host.req_dco,
                     div: host.req_div, trim: host.req_trim};
            // Dropped even if already low: every request runs the full sequence.
            pll_enable <= 1'b0;
            state      <= QUIESCE;
          end
        end
        QUIESCE: begin
          if (timer_zero) state <= LOAD;
        end
        LOAD: begin
          pll_div      <= cap.div;
          pll_ext_trim <= cap.trim;
          pll_dco      <= cap.dco;
          state        <= SETTLE;
        end
        SETTLE: begin
          if (timer_zero) begin
            if (cap.enable) begin
              pll_enable <= 1'b1;
              state      <= LOCK;
            end else begin
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        LOCK: begin
          if (timer_zero) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_cfg_writer.sv
// -----------------------------------------------------------------------------
// tb_pll_cfg_writer
// Directed bench for pll_cfg_writer. Each accepted request pushes its expected
// PLL settings and transfer-to-done latency onto a scoreboard; the entry is
// popped and compared when done pulses. A background monitor checks that the
// PLL settings never move while the oscillator stays enabled.
// -----------------------------------------------------------------------------
import pll_cfg_pkg::*;

module tb_pll_cfg_writer;

  typedef struct {
    cfg_t cfg;
    int   lat;
  } exp_t;

  logic              clock;
  logic              resetb;
  logic              pll_enable;
  logic              pll_dco;
  logic [DIV_W-1:0]  pll_div;
  logic [TRIM_W-1:0] pll_ext_trim;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];

  pll_cfg_writer_if cfg_if ();

  pll_cfg_writer dut (
    .clock        (clock),
    .resetb       (resetb),
    .host         (cfg_if),
    .pll_enable   (pll_enable),
    .pll_dco      (pll_dco),
    .pll_div      (pll_div),
    .pll_ext_trim (pll_ext_trim)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic cfg_t mk(input logic en, input logic dco,
                              input logic [DIV_W-1:0] div, input logic [TRIM_W-1:0] trim);
    cfg_t c;
    c.enable = en;
    c.dco    = dco;
    c.div    = div;
    c.trim   = trim;
    return c;
  endfunction

  // Drive a request at the current falling edge and record its expectation.
  // Unless hold is set, valid drops after the transfer edge.
  task automatic send(input cfg_t c, input int lat, input bit hold);
    exp_t e;
    cfg_if.req_valid  = 1'b1;
    cfg_if.req_div    = c.div;
    cfg_if.req_trim   = c.trim;
    cfg_if.req_dco    = c.dco;
    cfg_if.req_enable = c.enable;
    e.cfg = c;
    e.lat = lat;
    sb.push_back(e);
    if (!hold) begin
      @(negedge clock);
      cfg_if.req_valid = 1'b0;
    end
  endtask

  // Called with 'start' = cycles already elapsed since the transfer edge.
  // Waits (bounded) for done, pops the scoreboard and compares, then checks
  // that done lasts exactly one cycle.
  task automatic wait_done(input int start);
    int   cyc;
    bit   seen;
    exp_t e;
    cyc  = start;
    seen = 1'b0;
    while (!seen && cyc < start + 300) begin
      @(negedge clock);
      cyc++;
      if (cfg_if.done === 1'b1) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
    check("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("latency", cyc, e.lat);
      check("div", pll_div, e.cfg.div);
      check("trim", pll_ext_trim, e.cfg.trim);
      check("dco", pll_dco, e.cfg.dco);
      check("enable_at_done", pll_enable, e.cfg.enable);
    end
    check("ready_at_done", cfg_if.req_ready, 1'b1);
    check("busy_at_done", cfg_if.busy, 1'b0);
    @(negedge clock);
    check("done_one_cycle", cfg_if.done, 1'b0);
  endtask

  // Settings must hold while the oscillator is enabled.
  logic              prev_en   = 1'b0;
  logic              prev_dco  = 1'b0;
  logic [DIV_W-1:0]  prev_div  = '0;
  logic [TRIM_W-1:0] prev_trim = '0;

  always @(negedge clock) begin
    if (prev_en === 1'b1 && pll_enable === 1'b1) begin
      vectors++;
      assert ({pll_div, pll_ext_trim, pll_dco} === {prev_div, prev_trim, prev_dco}) else begin
        miscompares++;
        $error("FAIL stable_while_enabled: observed 0x%0h expected 0x%0h",
               {pll_div, pll_ext_trim, pll_dco}, {prev_div, prev_trim, prev_dco});
      end
    end
    prev_en   = pll_enable;
    prev_div  = pll_div;
    prev_trim = pll_ext_trim;
    prev_dco  = pll_dco;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_t a, b, c1, c2, d;
    bit   seen;

    a  = mk(1'b1, 1'b1, 5'd7,  26'h155_5555);
    b  = mk(1'b0, 1'b0, 5'd3,  26'h2AA_AAAA);
    c1 = mk(1'b0, 1'b1, 5'd9,  26'h012_3456);
    c2 = mk(1'b1, 1'b0, 5'd17, 26'h3C0_FFEE);
    d  = mk(1'b1, 1'b1, 5'd1,  26'h3FF_FFFF);

    resetb            = 1'b0;
    cfg_if.req_valid  = 1'b0;
    cfg_if.req_div    = '0;
    cfg_if.req_trim   = '0;
    cfg_if.req_dco    = 1'b0;
    cfg_if.req_enable = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_enable", pll_enable, 1'b0);
    check("rst_div", pll_div, 5'd4);
    check("rst_trim", pll_ext_trim, 26'h0);
    check("rst_dco", pll_dco, 1'b0);
    check("rst_ready", cfg_if.req_ready, 1'b1);
    check("rst_done", cfg_if.done, 1'b0);
    check("rst_busy", cfg_if.busy, 1'b0);
    resetb = 1'b1;
    @(negedge clock);
    check("idle_ready", cfg_if.req_ready, 1'b1);

    // Full sequence with re-enable, stepping through the phases
    send(a, 77, 1'b0);
    check("a_ready_low", cfg_if.req_ready, 1'b0);
    check("a_busy", cfg_if.busy, 1'b1);
    check("a_enable_low", pll_enable, 1'b0);
    repeat (8) @(negedge clock);
    check("a_div_before_load", pll_div, 5'd4);
    @(negedge clock);
    check("a_div_loaded", pll_div, 5'd7);
    check("a_trim_loaded", pll_ext_trim, 26'h155_5555);
    check("a_dco_loaded", pll_dco, 1'b1);
    check("a_enable_settle", pll_enable, 1'b0);
    repeat (4) @(negedge clock);
    check("a_enable_high", pll_enable, 1'b1);
    wait_done(13);

    // No re-enable, then the identical request again (no short-cut)
    send(b, 13, 1'b0);
    check("b_enable_dropped", pll_enable, 1'b0);
    wait_done(0);
    send(b, 13, 1'b0);
    wait_done(0);

    // valid held while busy with new data: ignored, then transfers on done
    send(c1, 13, 1'b1);
    @(negedge clock);
    send(c2, 77, 1'b1);
    wait_done(0);
    cfg_if.req_valid = 1'b0;
    check("c2_busy", cfg_if.busy, 1'b1);
    wait_done(0);

    // Reset during LOCK
    send(d, 77, 1'b0);
    repeat (20) @(negedge clock);
    check("d_in_lock_enable", pll_enable, 1'b1);
    check("d_in_lock_div", pll_div, 5'd1);
    #1 resetb = 1'b0;
    #1;
    check("mid_rst_enable", pll_enable, 1'b0);
    check("mid_rst_div", pll_div, 5'd4);
    check("mid_rst_trim", pll_ext_trim, 26'h0);
    check("mid_rst_dco", pll_dco, 1'b0);
    check("mid_rst_done", cfg_if.done, 1'b0);
    check("mid_rst_ready", cfg_if.req_ready, 1'b1);
    sb.delete();
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (cfg_if.done !== 1'b0) seen = 1'b1;
    end
    check("no_done_after_rst", seen, 1'b0);
    check("ready_after_rst", cfg_if.req_ready, 1'b1);

    // Fresh request after the aborted one
    send(b, 13, 1'b0);
    wait_done(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
